// File: rtl/simd_vload_assembler.sv
// Strided vector-load engine: fetches LANES elements over a single-outstanding
// request/grant port, packs them, and issues one register-file write strobe.
module simd_vload_assembler #(
   parameter int LANES = 8,
   parameter int DW    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [31:0]         base_addr,
   input  logic [31:0]         stride,
   input  logic [31:0]         dest,
   output logic                busy,
   output logic                mem_req,
   output logic [31:0]         mem_addr,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DW-1:0]       mem_rdata,
   output logic                DSIMD_EN,
   output logic [LANES*DW-1:0] DATA,
   output logic [31:0]         D_ADDR,
   output logic                done
);

   localparam int IW = $clog2(LANES);
   localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_WRITE = 2'd3;

   logic [1:0]                  state_q, state_d;
   logic [IW-1:0]               idx_q, idx_d;
   logic [31:0]                 addr_q, addr_d;
   logic [31:0]                 stride_q, stride_d;
   logic [31:0]                 dest_q, dest_d;
   logic [LANES-1:0][DW-1:0]    lanes_q, lanes_d;
   logic                        busy_q, busy_d;
   logic                        req_q, req_d;
   logic                        wr_q, wr_d;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      dest_d   = dest_q;
      lanes_d  = lanes_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d   = base_addr;
               stride_d = stride;
               dest_d   = dest;
               lanes_d  = '0;
               idx_d    = '0;
               state_d  = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_gnt) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               lanes_d[idx_q] = mem_rdata;
               if (idx_q == LAST_IDX) begin
                  state_d = S_WRITE;
               end else begin
                  // Address wraps modulo 2^32; a zero stride broadcasts one element.
                  idx_d   = idx_q + IW'(1);
                  addr_d  = addr_q + stride_q;
                  state_d = S_REQ;
               end
            end
         end
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Outputs are registered copies of the next-state decode.
      busy_d = (state_d != S_IDLE);
      req_d  = (state_d == S_REQ);
      wr_d   = (state_d == S_WRITE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         addr_q   <= '0;
         stride_q <= '0;
         dest_q   <= '0;
         lanes_q  <= '0;
         busy_q   <= 1'b0;
         req_q    <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         dest_q   <= dest_d;
         lanes_q  <= lanes_d;
         busy_q   <= busy_d;
         req_q    <= req_d;
         wr_q     <= wr_d;
      end
   end

   assign busy     = busy_q;
   assign mem_req  = req_q;
   assign mem_addr = addr_q;
   assign DSIMD_EN = wr_q;
   assign done     = wr_q;
   assign DATA     = lanes_q;
   assign D_ADDR   = dest_q;

endmodule
